// File: rtl/lspc_raster_timer_if.sv
// ---------------------------------------------------------------------------
// lspc_raster_timer_if
//
// Register bus between the LSPC register decoder and the raster timer block.
//
// Signals:
//   WR_EN    one-cycle write strobe from the decoder
//   WR_ADDR  {channel[1:0], reg[1:0]} of the write
//   WR_DATA  16-bit write data
//   RD_ADDR  {channel[1:0], reg[1:0]} of the read
//   RD_DATA  16-bit combinational read data returned by the timer
//
// Modports:
//   master  register decoder side (drives writes and read address)
//   slave   timer side (consumes writes, returns read data)
// ---------------------------------------------------------------------------
interface lspc_raster_timer_if;
  logic        WR_EN;
  logic [3:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic [3:0]  RD_ADDR;
  logic [15:0] RD_DATA;

  modport master (
    output WR_EN,
    output WR_ADDR,
    output WR_DATA,
    output RD_ADDR,
    input  RD_DATA
  );

  modport slave (
    input  WR_EN,
    input  WR_ADDR,
    input  WR_DATA,
    input  RD_ADDR,
    output RD_DATA
  );
endinterface

// File: rtl/lspc_raster_timer.sv
// ---------------------------------------------------------------------------
// lspc_raster_timer
//
// Multi-channel raster timer for the LSPC. Each of NCH channels owns a
// TIMER_W-bit down-counter clocked by the pixel strobe while the beam is in
// the active line range, a reload register, a control register and an IRQ
// pending flag. A counter that reaches zero produces a single zero event per
// load, unless auto-reload on zero is enabled.
//
// Parameters:
//   TIMER_W     counter/reload width (17..32)
//   NCH         number of channels (1..4)
//   VIDEO_MODE  1 = PAL (border stop honoured), 0 = NTSC (border stop ignored)
//
// Ports:
//   CLK_24M    sole clock, rising edge
//   nRESET     synchronous active-low reset
//   PIX_EN     pixel strobe, one CLK_24M cycle in four
//   VCOUNT     current line counter
//   VBL_START  one-cycle pulse at the first vblank line
//   bus        register bus (slave side): writes, reads
//   IRQ        per-channel pending flags (registered)
//   IRQ_ANY    OR of IRQ
// ---------------------------------------------------------------------------
module lspc_raster_timer #(
  parameter int TIMER_W    = 32,
  parameter int NCH        = 2,
  parameter int VIDEO_MODE = 1
) (
  input  logic                   CLK_24M,
  input  logic                   nRESET,
  input  logic                   PIX_EN,
  input  logic [8:0]             VCOUNT,
  input  logic                   VBL_START,
  lspc_raster_timer_if.slave     bus,
  output logic [NCH-1:0]         IRQ,
  output logic                   IRQ_ANY
);

  localparam bit PAL = (VIDEO_MODE != 0);

  // CTRL bit positions
  localparam int IRQ_EN      = 0;
  localparam int RLD_WR      = 1;
  localparam int RLD_VBL     = 2;
  localparam int RLD_ZERO    = 3;
  localparam int BORDER_STOP = 4;

  // Register indices inside a channel
  localparam logic [1:0] REG_LOAD_HI = 2'd0;
  localparam logic [1:0] REG_LOAD_LO = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_ACK     = 2'd3;

  logic [TIMER_W-1:0] count  [NCH];
  logic [TIMER_W-1:0] reload [NCH];
  logic [4:0]         ctrl   [NCH];
  logic [NCH-1:0]     expired;
  logic [NCH-1:0]     pending;

  logic [1:0] wr_ch;
  logic [1:0] wr_reg;
  logic [1:0] rd_ch;
  logic [1:0] rd_reg;
  logic       border;

  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] step;
  logic [NCH-1:0] zero_evt;
  logic [NCH-1:0] load_wr;
  logic [NCH-1:0] load_vbl;
  logic [NCH-1:0] ack;

  // Only the upper line bits matter for run/border decisions.
  logic unused_vcount_lo;
  assign unused_vcount_lo = ^VCOUNT[3:0];

  assign wr_ch  = bus.WR_ADDR[3:2];
  assign wr_reg = bus.WR_ADDR[1:0];
  assign rd_ch  = bus.RD_ADDR[3:2];
  assign rd_reg = bus.RD_ADDR[1:0];

  // The border is the first and last 16 lines of the visible half-range.
  assign border = (VCOUNT[7:4] == 4'h0) | (VCOUNT[7:4] == 4'hF);

  // Per-channel event decode. Channels whose index is >= NCH never match a
  // write, which is how out-of-range writes are dropped.
  always_comb begin
    wr_hit   = '0;
    step     = '0;
    zero_evt = '0;
    load_wr  = '0;
    load_vbl = '0;
    ack      = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_hit[c]   = bus.WR_EN & (wr_ch == 2'(c));
      step[c]     = PIX_EN & VCOUNT[8] & ~(PAL & ctrl[c][BORDER_STOP] & border);
      zero_evt[c] = step[c] & (count[c] == '0) & ~expired[c];
      load_wr[c]  = wr_hit[c] & (wr_reg == REG_LOAD_LO) & ctrl[c][RLD_WR];
      load_vbl[c] = VBL_START & ctrl[c][RLD_VBL];
      ack[c]      = wr_hit[c] & (wr_reg == REG_ACK) & bus.WR_DATA[0];
    end
  end

  // Channel state. The counter update is a strict priority chain: a write
  // load beats a vblank reload, which beats a zero-event reload, which beats
  // a plain decrement. PENDING is set by the zero event even when a higher
  // priority load takes the counter, and a set beats a same-cycle ACK.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      for (int c = 0; c < NCH; c++) begin
        count[c]  <= '0;
        reload[c] <= '0;
        ctrl[c]   <= '0;
      end
      expired <= '1;
      pending <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_hit[c]) begin
          case (wr_reg)
            REG_LOAD_HI: reload[c][TIMER_W-1:16] <= bus.WR_DATA[TIMER_W-17:0];
            REG_LOAD_LO: reload[c][15:0]         <= bus.WR_DATA;
            REG_CTRL:    ctrl[c]                 <= bus.WR_DATA[4:0];
            default:     ;
          endcase
        end

        if (load_wr[c]) begin
          count[c]   <= {reload[c][TIMER_W-1:16], bus.WR_DATA};
          expired[c] <= 1'b0;
        end else if (load_vbl[c]) begin
          count[c]   <= reload[c];
          expired[c] <= 1'b0;
        end else if (zero_evt[c]) begin
          if (ctrl[c][RLD_ZERO]) begin
            count[c] <= reload[c];
          end else begin
            expired[c] <= 1'b1;
          end
        end else if (step[c] && (count[c] != '0)) begin
          count[c] <= count[c] - 1'b1;
        end

        if (zero_evt[c] && ctrl[c][IRQ_EN]) begin
          pending[c] <= 1'b1;
        end else if (ack[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // Combinational register read; unimplemented channels read as zero.
  always_comb begin
    bus.RD_DATA = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == 2'(c)) begin
        case (rd_reg)
          REG_LOAD_HI: bus.RD_DATA = 16'(count[c][TIMER_W-1:16]);
          REG_LOAD_LO: bus.RD_DATA = count[c][15:0];
          REG_CTRL:    bus.RD_DATA = {11'b0, ctrl[c]};
          default:     bus.RD_DATA = {14'b0, expired[c], pending[c]};
        endcase
      end
    end
  end

  assign IRQ     = pending;
  assign IRQ_ANY = |pending;

endmodule

// File: tb/tb_lspc_raster_timer.sv
// ---------------------------------------------------------------------------
// tb_lspc_raster_timer
//
// Drives three timer builds with identical stimulus:
//   d0: TIMER_W=32, NCH=2, PAL
//   d1: TIMER_W=32, NCH=2, NTSC
//   d2: TIMER_W=24, NCH=3, PAL
// A behavioural model tracks every channel of every build; a compare process
// sweeps all 16 read addresses plus IRQ/IRQ_ANY on each low clock phase.
// ---------------------------------------------------------------------------
module tb_lspc_raster_timer;

  logic        CLK_24M;
  logic        nReset;
  logic        pixEn;
  logic [8:0]  vcount;
  logic        vblStart;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [15:0] wrData;
  logic        checkEn;

  int checks;
  int errors;

  lspc_raster_timer_if busA ();
  lspc_raster_timer_if busB ();
  lspc_raster_timer_if busC ();

  logic [1:0] irqA;
  logic [1:0] irqB;
  logic [2:0] irqC;
  logic       anyA;
  logic       anyB;
  logic       anyC;

  lspc_raster_timer #(.TIMER_W(32), .NCH(2), .VIDEO_MODE(1)) dutPal (
    .CLK_24M(CLK_24M), .nRESET(nReset), .PIX_EN(pixEn), .VCOUNT(vcount),
    .VBL_START(vblStart), .bus(busA), .IRQ(irqA), .IRQ_ANY(anyA)
  );

  lspc_raster_timer #(.TIMER_W(32), .NCH(2), .VIDEO_MODE(0)) dutNtsc (
    .CLK_24M(CLK_24M), .nRESET(nReset), .PIX_EN(pixEn), .VCOUNT(vcount),
    .VBL_START(vblStart), .bus(busB), .IRQ(irqB), .IRQ_ANY(anyB)
  );

  lspc_raster_timer #(.TIMER_W(24), .NCH(3), .VIDEO_MODE(1)) dutNarrow (
    .CLK_24M(CLK_24M), .nRESET(nReset), .PIX_EN(pixEn), .VCOUNT(vcount),
    .VBL_START(vblStart), .bus(busC), .IRQ(irqC), .IRQ_ANY(anyC)
  );

  initial begin
    CLK_24M = 1'b0;
    forever #20 CLK_24M = ~CLK_24M;
  end

  // Behavioural model state, indexed [build][channel]
  logic [31:0] mCount  [3][4];
  logic [31:0] mReload [3][4];
  logic [4:0]  mCtrl   [3][4];
  logic        mExp    [3][4];
  logic        mPend   [3][4];

  function automatic int nchOf(int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] maskOf(int d);
    return (d == 2) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit palOf(int d);
    return d != 1;
  endfunction

  function automatic logic [3:0] dutIrq(int d);
    case (d)
      0:       return {2'b0, irqA};
      1:       return {2'b0, irqB};
      default: return {1'b0, irqC};
    endcase
  endfunction

  function automatic logic dutAny(int d);
    case (d)
      0:       return anyA;
      1:       return anyB;
      default: return anyC;
    endcase
  endfunction

  function automatic logic [15:0] dutRd(int d);
    case (d)
      0:       return busA.RD_DATA;
      1:       return busB.RD_DATA;
      default: return busC.RD_DATA;
    endcase
  endfunction

  function automatic logic [3:0] modelIrq(int d);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < nchOf(d); c++) v[c] = mPend[d][c];
    return v;
  endfunction

  function automatic logic [15:0] expRead(int d, int a);
    int ch;
    int r;
    ch = a / 4;
    r  = a % 4;
    if (ch >= nchOf(d)) return 16'h0;
    case (r)
      0:       return 16'(mCount[d][ch] >> 16);
      1:       return mCount[d][ch][15:0];
      2:       return {11'b0, mCtrl[d][ch]};
      default: return {14'b0, mExp[d][ch], mPend[d][ch]};
    endcase
  endfunction

  // Apply the rules of one clock edge to the model, using the inputs the
  // DUTs sampled on that edge.
  task automatic modelUpdate();
    int          wch;
    int          wreg;
    logic [31:0] cnt;
    logic [31:0] rel;
    logic [31:0] nextCnt;
    logic [4:0]  ctl;
    logic        nextExp;
    logic        nextPend;
    bit          hit;
    bit          running;
    bit          fire;
    bit          inBorder;
    wch      = int'(wrAddr[3:2]);
    wreg     = int'(wrAddr[1:0]);
    inBorder = (vcount[7:4] == 4'h0) || (vcount[7:4] == 4'hF);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (!nReset) begin
          mCount[d][c]  = '0;
          mReload[d][c] = '0;
          mCtrl[d][c]   = '0;
          mExp[d][c]    = 1'b1;
          mPend[d][c]   = 1'b0;
        end else if (c < nchOf(d)) begin
          cnt      = mCount[d][c];
          rel      = mReload[d][c];
          ctl      = mCtrl[d][c];
          hit      = wrEn && (wch == c);
          running  = vcount[8] && !(palOf(d) && ctl[4] && inBorder);
          fire     = pixEn && running && (cnt == 0) && !mExp[d][c];
          nextCnt  = cnt;
          nextExp  = mExp[d][c];
          nextPend = mPend[d][c];
          // Later rules override earlier ones (lowest priority first).
          if (pixEn && running && cnt != 0) nextCnt = (cnt - 1) & maskOf(d);
          if (fire) begin
            if (ctl[3]) nextCnt = rel;
            else        nextExp = 1'b1;
          end
          if (vblStart && ctl[2]) begin
            nextCnt = rel;
            nextExp = 1'b0;
          end
          if (hit && wreg == 1 && ctl[1]) begin
            nextCnt = ((rel & 32'hFFFF_0000) | {16'b0, wrData}) & maskOf(d);
            nextExp = 1'b0;
          end
          if (hit && wreg == 3 && wrData[0]) nextPend = 1'b0;
          if (fire && ctl[0]) nextPend = 1'b1;
          if (hit && wreg == 0)
            mReload[d][c] = ((rel & 32'h0000_FFFF) | ({16'b0, wrData} << 16)) & maskOf(d);
          if (hit && wreg == 1)
            mReload[d][c] = (rel & 32'hFFFF_0000) | {16'b0, wrData};
          if (hit && wreg == 2) mCtrl[d][c] = wrData[4:0];
          mCount[d][c] = nextCnt;
          mExp[d][c]   = nextExp;
          mPend[d][c]  = nextPend;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare process: on every low phase, check IRQ lines and sweep all reads.
  initial begin
    busA.RD_ADDR = '0;
    busB.RD_ADDR = '0;
    busC.RD_ADDR = '0;
    forever begin
      @(negedge CLK_24M);
      if (checkEn) begin
        for (int d = 0; d < 3; d++) begin
          checkOutput($sformatf("d%0d_irq", d), 32'(dutIrq(d)), 32'(modelIrq(d)));
          checkOutput($sformatf("d%0d_irq_any", d), 32'(dutAny(d)), 32'(|modelIrq(d)));
        end
        for (int a = 0; a < 16; a++) begin
          busA.RD_ADDR = 4'(a);
          busB.RD_ADDR = 4'(a);
          busC.RD_ADDR = 4'(a);
          #1;
          for (int d = 0; d < 3; d++)
            checkOutput($sformatf("d%0d_rd%0d", d, a), 32'(dutRd(d)), 32'(expRead(d, a)));
        end
      end
    end
  end

  task automatic driveBuses();
    busA.WR_EN = wrEn; busA.WR_ADDR = wrAddr; busA.WR_DATA = wrData;
    busB.WR_EN = wrEn; busB.WR_ADDR = wrAddr; busB.WR_DATA = wrData;
    busC.WR_EN = wrEn; busC.WR_ADDR = wrAddr; busC.WR_DATA = wrData;
  endtask

  // One clock with the given inputs; the model follows the same edge.
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [15:0] dta,
                               input logic p, input logic v);
    wrEn = w; wrAddr = a; wrData = dta; pixEn = p; vblStart = v;
    driveBuses();
    @(posedge CLK_24M);
    modelUpdate();
    #1;
    wrEn = 1'b0; wrAddr = '0; wrData = '0; pixEn = 1'b0; vblStart = 1'b0;
    driveBuses();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input int n);
    repeat (n) begin
      idle(3);
      applyStimulus(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic writeReg(input logic [1:0] ch, input logic [1:0] r, input logic [15:0] dta);
    applyStimulus(1'b1, {ch, r}, dta, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    checkEn  = 1'b0;
    nReset   = 1'b0;
    vcount   = 9'h120;
    wrEn     = 1'b0; wrAddr = '0; wrData = '0; pixEn = 1'b0; vblStart = 1'b0;
    driveBuses();

    // Reset, including a write and strobes that must be ignored
    idle(1);
    checkEn = 1'b1;
    applyStimulus(1'b1, 4'b0001, 16'h0005, 1'b1, 1'b1);
    nReset = 1'b1;
    idle(1);
    checkOutput("rst_irqA", 32'(irqA), 0);
    checkOutput("rst_irqC", 32'(irqC), 0);
    checkOutput("rst_exp", 32'(mExp[2][2]), 1);

    // One-shot load of 5: fires on the 6th running strobe, never again
    writeReg(2'd0, 2'd2, 16'h0003);
    writeReg(2'd0, 2'd0, 16'h0000);
    writeReg(2'd0, 2'd1, 16'h0005);
    pixels(5);
    checkOutput("n5_irq_pre", 32'(irqA[0]), 0);
    checkOutput("n5_count_pre", mCount[0][0], 0);
    pixels(1);
    checkOutput("n5_irq_fire", 32'(irqA[0]), 1);
    checkOutput("n5_irq_ntsc", 32'(irqB[0]), 1);
    checkOutput("n5_expired", 32'(mExp[0][0]), 1);
    writeReg(2'd0, 2'd3, 16'h0001);
    checkOutput("n5_ack", 32'(irqA[0]), 0);
    pixels(4);
    checkOutput("n5_no_refire", 32'(irqA[0]), 0);

    // Auto-reload on zero with RELOAD=3: an event every 4 strobes
    writeReg(2'd1, 2'd2, 16'h000B);
    writeReg(2'd1, 2'd1, 16'h0003);
    pixels(3);
    checkOutput("rz_pre", 32'(irqA[1]), 0);
    pixels(1);
    checkOutput("rz_fire1", 32'(irqA[1]), 1);
    checkOutput("rz_reload", mCount[0][1], 3);
    writeReg(2'd1, 2'd3, 16'h0001);
    checkOutput("rz_ack", 32'(irqA[1]), 0);
    pixels(3);
    checkOutput("rz_gap", 32'(irqA[1]), 0);
    pixels(1);
    checkOutput("rz_fire2", 32'(irqA[1]), 1);
    writeReg(2'd1, 2'd3, 16'h0001);
    writeReg(2'd1, 2'd2, 16'h0000);

    // Border stop: frozen in PAL border, counting in NTSC or outside border
    writeReg(2'd0, 2'd2, 16'h0013);
    writeReg(2'd0, 2'd1, 16'h000A);
    vcount = 9'h108;
    pixels(3);
    checkOutput("bs_pal", mCount[0][0], 10);
    checkOutput("bs_ntsc", mCount[1][0], 7);
    vcount = 9'h110;
    pixels(2);
    checkOutput("bs_active_pal", mCount[0][0], 8);
    vcount = 9'h0F8;
    pixels(2);
    checkOutput("bit8_pal", mCount[0][0], 8);
    checkOutput("bit8_ntsc", mCount[1][0], 5);
    vcount = 9'h120;

    // Collision: LOAD_LO with RLD_WR on the zero-event strobe
    writeReg(2'd0, 2'd2, 16'h0003);
    writeReg(2'd0, 2'd1, 16'h0002);
    pixels(2);
    idle(3);
    applyStimulus(1'b1, 4'b0001, 16'h0007, 1'b1, 1'b0);
    checkOutput("col_ld_count", mCount[0][0], 7);
    checkOutput("col_ld_irq", 32'(irqA[0]), 1);
    writeReg(2'd0, 2'd3, 16'h0001);

    // Collision: ACK on the cycle the flag is set
    writeReg(2'd0, 2'd1, 16'h0001);
    pixels(1);
    idle(3);
    applyStimulus(1'b1, 4'b0011, 16'h0001, 1'b1, 1'b0);
    checkOutput("col_ack_irq", 32'(irqA[0]), 1);
    writeReg(2'd0, 2'd3, 16'h0001);

    // Vblank reload
    writeReg(2'd1, 2'd2, 16'h0005);
    writeReg(2'd1, 2'd1, 16'h0020);
    applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("vbl_count", mCount[0][1], 32'h20);
    pixels(1);
    checkOutput("vbl_dec", mCount[0][1], 32'h1F);

    // Narrow build: third channel, LOAD_HI truncation, channel 3 ignored
    writeReg(2'd2, 2'd0, 16'hFFAB);
    writeReg(2'd2, 2'd2, 16'h0003);
    writeReg(2'd2, 2'd1, 16'h0001);
    checkOutput("n24_load", mCount[2][2], 32'h00AB_0001);
    writeReg(2'd3, 2'd2, 16'h001F);
    writeReg(2'd3, 2'd1, 16'h0005);
    writeReg(2'd3, 2'd3, 16'h0001);
    pixels(2);
    checkOutput("n24_dec", mCount[2][2], 32'h00AA_FFFF);
    writeReg(2'd0, 2'd0, 16'hFFAB);
    writeReg(2'd0, 2'd1, 16'h0004);
    checkOutput("hi_w32", mCount[0][0], 32'hFFAB_0004);
    checkOutput("hi_w24", mCount[2][0], 32'h00AB_0004);
    pixels(3);

    // Reset mid-count with a simultaneous write and strobes
    nReset = 1'b0;
    applyStimulus(1'b1, 4'b0001, 16'h0009, 1'b1, 1'b1);
    nReset = 1'b1;
    pixels(6);
    checkOutput("rst2_anyA", 32'(anyA), 0);
    checkOutput("rst2_anyC", 32'(anyC), 0);
    checkOutput("rst2_exp", 32'(mExp[2][2]), 1);
    checkOutput("rst2_count", mCount[0][0], 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
